ps2_keycode: RTL and testbench

PS2_KEYCODE -- requirements
Module: ps2_keycode

---
 rtl/ps2_keycode.sv | 132 +++++++++++++
 tb/tb_ps2_keycode.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ps2_keycode.sv
// ps2_keycode: PS/2 keyboard receiver that turns scan-code set 2 frames into a held-key HID usage code.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not match.
module ps2_keycode #(
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       key_valid,
   output logic       frame_err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t        state;
   logic [1:0]    clk_s, data_s;
   logic          clk_q, fall, bit_in, par_ok;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift, code, next_key;
   logic [TW-1:0] tmo_cnt;
   logic          byte_stb, tmo_stb, ext, brk, mapped;
`ifdef PS2_PARITY_CHECK_EN
   logic          par;
   assign par_ok = ^{shift, par};
`else
   assign par_ok = 1'b1;
`endif
   always_ff @(posedge Clk) begin
      if (Reset) begin
         clk_s  <= 2'b11;
         data_s <= 2'b11;
         clk_q  <= 1'b1;
      end else begin
         clk_s  <= {clk_s[0], ps2_clk};
         data_s <= {data_s[0], ps2_data};
         clk_q  <= clk_s[1];
      end
   end
   assign fall   = clk_q & ~clk_s[1];
   assign bit_in = data_s[1];
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         tmo_cnt   <= '0;
         byte_stb  <= 1'b0;
         tmo_stb   <= 1'b0;
         frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par       <= 1'b0;
`endif
      end else begin
         byte_stb  <= 1'b0;
         tmo_stb   <= 1'b0;
         frame_err <= 1'b0;
         tmo_cnt   <= (state == IDLE || fall) ? '0 : tmo_cnt + 1'b1;
         if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            tmo_stb   <= 1'b1;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  state   <= bit_in ? IDLE : DATA;
                  bit_cnt <= '0;
               end
               DATA: begin
                  shift   <= {bit_in, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  state   <= (bit_cnt == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  par   <= bit_in;
`endif
                  state <= STOP;
               end
               STOP: begin
                  state     <= IDLE;
                  byte_stb  <= bit_in & par_ok;
                  frame_err <= ~(bit_in & par_ok);
               end
            endcase
         end
      end
   end
   // Extended (E0-prefixed) codes use a separate table; 0x00 marks an unmapped byte.
   always_comb begin
      code = ext ? (shift == 8'h75 ? 8'h52 :
                    shift == 8'h72 ? 8'h51 :
                    shift == 8'h6B ? 8'h50 :
                    shift == 8'h74 ? 8'h4F :
                    shift == 8'h5A ? 8'h28 : 8'h00)
                 : (shift == 8'h1D ? 8'h1A :
                    shift == 8'h1B ? 8'h16 :
                    shift == 8'h1C ? 8'h04 :
                    shift == 8'h23 ? 8'h07 :
                    shift == 8'h5A ? 8'h28 :
                    shift == 8'h29 ? 8'h2C : 8'h00);
      mapped   = code != 8'h00;
      next_key = brk ? ((code == keycode) ? 8'h00 : keycode) : code;
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         keycode   <= 8'h00;
         key_valid <= 1'b0;
         ext       <= 1'b0;
         brk       <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (tmo_stb) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_stb) begin
            if (shift == 8'hE0) ext <= 1'b1;
            else if (shift == 8'hF0) brk <= 1'b1;
            else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (mapped && next_key != keycode) begin
                  keycode   <= next_key;
                  key_valid <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_keycode.sv
// tb_ps2_keycode: directed PS/2 frames with hand-computed keycodes, pulse counts and latency.
module tb_ps2_keycode;
   localparam int H = 20;
   logic       Clk = 1'b0, Reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [7:0] keycode;
   logic       key_valid, frame_err;
   int         vectors = 0, errors = 0, kv_cnt = 0, fe_cnt = 0, k0, f0;
   ps2_keycode #(.TIMEOUT_CYCLES(200)) dut (
      .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keycode(keycode), .key_valid(key_valid), .frame_err(frame_err)
   );
   always #5 Clk = ~Clk;
   always @(negedge Clk) begin
      if (key_valid) kv_cnt++;
      if (frame_err) fe_cnt++;
   end
   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask
   task automatic drive_bit(input logic b);
      ps2_data = b;
      step(H);
      ps2_clk = 1'b0;
   endtask
   task automatic rise();
      step(H);
      ps2_clk = 1'b1;
   endtask
   // Returns right after the stop-bit falling edge is driven.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      logic [10:0] bits;
      bits = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         drive_bit(bits[i]);
         if (i < 10) rise();
      end
   endtask
   task automatic frame(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0);
      rise();
      step(H);
   endtask
   task automatic partial(input logic [7:0] b, input int n);
      drive_bit(1'b0);
      rise();
      for (int i = 0; i < n; i++) begin
         drive_bit(b[i]);
         rise();
      end
   endtask
   initial begin
      step(3);
      Reset = 1'b0;
      step(1);
      chk("rst_kc", keycode, 8'h00);
      chk("rst_kv", key_valid, 0);
      chk("rst_fe", frame_err, 0);
      k0 = kv_cnt;
      send_frame(8'h1D, 1'b0, 1'b0);
      step(1); chk("lat1_kc", keycode, 8'h00);
      step(1); chk("lat2_kc", keycode, 8'h00);
      step(1); chk("lat3_kc", keycode, 8'h00);
      step(1); chk("lat4_kc", keycode, 8'h1A); chk("lat4_kv", key_valid, 1);
      step(1); chk("lat5_kv", key_valid, 0);
      rise();
      step(H);
      chk("w_pulses", kv_cnt - k0, 1);
      k0 = kv_cnt;
      frame(8'h1C);
      chk("a_kc", keycode, 8'h04);
      chk("a_kv", kv_cnt - k0, 1);
      k0 = kv_cnt;
      frame(8'hF0); frame(8'h1D);
      chk("w_brk_kc", keycode, 8'h04);
      chk("w_brk_kv", kv_cnt - k0, 0);
      frame(8'h1C);
      chk("a_rep_kv", kv_cnt - k0, 0);
      frame(8'h15);
      chk("unmap_kc", keycode, 8'h04);
      frame(8'hF0); frame(8'h1C);
      chk("a_brk_kc", keycode, 8'h00);
      chk("a_brk_kv", kv_cnt - k0, 1);
      frame(8'hE0); frame(8'h75);
      chk("up_kc", keycode, 8'h52);
      frame(8'hE0); frame(8'hF0); frame(8'h75);
      chk("up_brk_kc", keycode, 8'h00);
      k0 = kv_cnt;
      frame(8'h75);
      chk("plain75_kc", keycode, 8'h00);
      chk("plain75_kv", kv_cnt - k0, 0);
      frame(8'hE0); frame(8'h5A);
      chk("kpent_kc", keycode, 8'h28);
      frame(8'hF0); frame(8'h5A);
      chk("kpent_brk", keycode, 8'h00);
      f0 = fe_cnt;
      send_frame(8'h23, 1'b1, 1'b0);
      rise();
      step(H);
`ifdef PS2_PARITY_CHECK_EN
      chk("par_kc", keycode, 8'h00);
      chk("par_fe", fe_cnt - f0, 1);
`else
      chk("par_kc", keycode, 8'h07);
      chk("par_fe", fe_cnt - f0, 0);
      frame(8'hF0); frame(8'h23);
      chk("d_brk_kc", keycode, 8'h00);
`endif
      f0 = fe_cnt;
      send_frame(8'h1D, 1'b0, 1'b1);
      rise();
      step(H);
      chk("stop_kc", keycode, 8'h00);
      chk("stop_fe", fe_cnt - f0, 1);
      frame(8'hE0);
      f0 = fe_cnt;
      partial(8'h05, 3);
      step(100);
      chk("tmo_early", fe_cnt - f0, 0);
      step(150);
      chk("tmo_fe", fe_cnt - f0, 1);
      frame(8'h75);
      chk("tmo_ext_clr", keycode, 8'h00);
      frame(8'h5A);
      chk("tmo_ent_kc", keycode, 8'h28);
      frame(8'hF0); frame(8'h5A);
      chk("ent_brk_kc", keycode, 8'h00);
      partial(8'h1B, 4);
      Reset = 1'b1;
      step(2);
      Reset = 1'b0;
      step(2);
      f0 = fe_cnt;
      frame(8'h1B);
      chk("rstmid_kc", keycode, 8'h16);
      chk("rstmid_fe", fe_cnt - f0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
